hex_line_formatter: RTL and testbench
=====================================

# hex_line_formatter

Synthesizable downstream consumer of the processor's 8-bit test-value port. Captures each `o_value`/`o_value_wr` strobe into a small FIFO and re-emits every value as three ASCII characters: two hex digits followed by an end-of-line byte, matching the `%02h` line format. Output uses a valid/ready byte stream, suitable for a UART transmitter or a capture port. On the processor's termination strobe it drains the FIFO and then raises a sticky done flag.

## Interface
- `L_DEPTH`, default 3: log2 of the FIFO depth; depth = 2**L_DEPTH values.
- `G_UPPERCASE`, default 0: 0 emits digits a–f as 8'h61–8'h66; 1 emits A–F as 8'h41–8'h46.
- `G_EOL`, default 8'h0A: byte emitted after the two hex digits.
- `i_clk`  in  1: processor clock; all logic is on the rising edge.
- `i_rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `i_value`  in  8: value from the processor's `o_value`.
- `i_value_wr`  in  1: single-cycle write strobe from the processor's `o_value_wr`.
- `i_terminate_str`  in  1: single-cycle termination strobe.
- `o_char`  out  8: ASCII byte.
- `o_char_valid`  out  1: `o_char` is valid.
- `i_char_ready`  in  1: the sink accepts `o_char` this cycle.
- `o_done`  out  1: sticky; the drain after termination is complete.
- `o_overflow`  out  1: sticky; at least one value was dropped.

## Operation
- **FIFO:** depth 2**L_DEPTH, with pointers of L_DEPTH+1 bits (the extra bit is the wrap flag).
  - A write is accepted when `i_value_wr` is high, the FIFO is not full, and termination has not yet been latched.
  - A write in the same cycle as `i_terminate_str` is accepted.
  - A write while full is dropped and sets `o_overflow`. This holds even if a pop occurs in the same cycle; fullness is sampled before the edge.
  - A simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
- **Hex mapping:** nibble 0–9 maps to 8'h30+n. Nibble 10–15 maps to (G_UPPERCASE ? 8'h41 : 8'h61)+n-10.
- **Transfer:** a transfer occurs when `o_char_valid && i_char_ready`.
- **FSM states:** S_IDLE, S_HI, S_LO, S_EOL.
  - S_IDLE: if the FIFO is not empty, pop one value into the hold register, set `o_char`=hex(value[7:4]) and `o_char_valid`=1, and go to S_HI. Otherwise stay, with valid=0.
  - S_HI: on transfer, set `o_char`=hex(hold[3:0]) and go to S_LO.
  - S_LO: on transfer, set `o_char`=G_EOL and go to S_EOL.
  - S_EOL: on transfer, if the FIFO is not empty, pop and load the next high digit, then go to S_HI. Otherwise set valid=0 and go to S_IDLE.
  - In every state, a missing transfer holds state, `o_char` and `o_char_valid` unchanged.
- **Termination:** `i_terminate_str` sets the internal `term_seen` flag, which is sticky.
  - `o_done` is set on the edge where `term_seen`, FIFO empty, and state S_IDLE are all true with no pending push.
  - Once set, `o_done` stays high until reset.
- **Reset:** `i_rst` aborts any character in flight. It clears the FIFO pointers, FSM (to S_IDLE), `term_seen`, and the hold register. Reset wins over all simultaneous events.

## Timing
- **Reset values:** `o_char`=8'h00, `o_char_valid`=0, `o_done`=0, `o_overflow`=0.
- **Latency into an idle, empty block:** a write at cycle N gives the FIFO non-empty at N+1 and the first character valid at N+2.
- **Throughput with `i_char_ready` held high:** hi at N+2, lo at N+3, EOL at N+4.
  - A queued next value produces its hi digit at N+5, with no bubble between values.
- **Sustained rate:** 3 cycles per value. The FIFO absorbs bursts up to 2**L_DEPTH beyond the value currently in flight.
- **`o_done` timing:** with termination already seen, `o_done` rises one cycle after the final EOL transfer.
- **Stream rule:** `o_char` never changes while `o_char_valid`=1 and `i_char_ready`=0.

## Test plan
- **Single value:** reset, then write 8'hA5 with ready=1. Expect `o_char` 8'h61, 8'h35, 8'h0A on three consecutive valid cycles starting 2 cycles after the write, then valid=0.
- **Back-to-back:** write 8'h00, 8'hFF, 8'h3C on consecutive cycles with ready=1. Expect 30 30 0A 66 66 0A 33 63 0A, contiguous with no gaps.
- **Backpressure:** write 8'h7E and hold ready=0 for 5 cycles after valid rises. Expect `o_char`=8'h37 to stay stable for those cycles. Release ready and expect 37 37… correction: expect 37 65 0A.
- **Overflow:** L_DEPTH=3, ready=0, write 8'h01 through 8'h0A on 10 consecutive cycles.
  - Expect 8'h01 in the hold register and 8'h02–8'h09 in the FIFO.
  - Expect 8'h0A dropped and `o_overflow`=1.
  - After ready=1, expect nine lines "01" through "09".
- **Termination drain:** write 8'h12 and 8'h34, pulse terminate on the same cycle as the second write, then write 8'h56.
  - Expect lines "12" and "34"; 8'h56 is ignored.
  - Expect `o_done` to rise one cycle after the last 0A transfer and stay high.
- **Reset mid-stream and G_UPPERCASE=1:** assert reset while in S_LO. Expect valid=0, done=0, overflow=0 next cycle. Then write 8'hBE and expect 42 45 0A.

Source files
------------

// File: rtl/hex_line_formatter.sv
// hex_line_formatter: captures processor test values into a FIFO and
// re-emits each one as two ASCII hex digits plus an end-of-line byte.
module hex_line_formatter #(
  parameter int         L_DEPTH     = 3,
  parameter bit         G_UPPERCASE = 1'b0,
  parameter logic [7:0] G_EOL       = 8'h0A
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_value,
  input  logic       i_value_wr,
  input  logic       i_terminate_str,
  output logic [7:0] o_char,
  output logic       o_char_valid,
  input  logic       i_char_ready,
  output logic       o_done,
  output logic       o_overflow
);

  localparam int DEPTH = 2 ** L_DEPTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_EOL
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [DEPTH];
  logic [L_DEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [L_DEPTH:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       hold_q, hold_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic             term_q, term_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;

  logic       empty;
  logic       full;
  logic       push;
  logic       pop;
  logic       xfer;
  logic [7:0] head;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] alpha;
    alpha = G_UPPERCASE ? 8'h41 : 8'h61;
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return alpha + {4'h0, n} - 8'd10;
  endfunction

  // Extra pointer bit tells a full FIFO apart from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[L_DEPTH] != rd_ptr_q[L_DEPTH]) &&
                 (wr_ptr_q[L_DEPTH-1:0] == rd_ptr_q[L_DEPTH-1:0]);
  assign head  = mem_q[rd_ptr_q[L_DEPTH-1:0]];
  assign push  = i_value_wr & ~full & ~term_q;
  assign xfer  = valid_q & i_char_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    char_d  = char_q;
    valid_d = valid_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          hold_d  = head;
          char_d  = hex_char(head[7:4]);
          valid_d = 1'b1;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (xfer) begin
          char_d  = hex_char(hold_q[3:0]);
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (xfer) begin
          char_d  = G_EOL;
          state_d = S_EOL;
        end
      end
      S_EOL: begin
        if (xfer) begin
          if (!empty) begin
            pop     = 1'b1;
            hold_d  = head;
            char_d  = hex_char(head[7:4]);
            state_d = S_HI;
          end else begin
            valid_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{L_DEPTH{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{L_DEPTH{1'b0}}, pop};
    term_d   = term_q | i_terminate_str;
    ovf_d    = ovf_q | (i_value_wr & full);
    done_d   = done_q |
               (term_q & empty & ~push & (state_q == S_IDLE));
  end

  // Storage needs no reset; the pointers alone define its contents.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[L_DEPTH-1:0]] <= i_value;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= 8'h00;
      char_q   <= 8'h00;
      valid_q  <= 1'b0;
      term_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      hold_q   <= hold_d;
      char_q   <= char_d;
      valid_q  <= valid_d;
      term_q   <= term_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_char       = char_q;
  assign o_char_valid = valid_q;
  assign o_done       = done_q;
  assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_hex_line_formatter.sv
// Scoreboard bench for hex_line_formatter: lowercase and uppercase
// instances share stimulus, a negedge monitor pops expected bytes.
module tb_hex_line_formatter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value;
  logic       wr;
  logic       term;
  logic       ready;
  logic [7:0] char0, char1;
  logic       valid0, valid1;
  logic       done0, done1;
  logic       ovf0, ovf1;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  hex_line_formatter #(
    .L_DEPTH(3), .G_UPPERCASE(1'b0), .G_EOL(8'h0A)
  ) u_lo (
    .i_clk(clk), .i_rst(rst), .i_value(value),
    .i_value_wr(wr), .i_terminate_str(term),
    .o_char(char0), .o_char_valid(valid0),
    .i_char_ready(ready), .o_done(done0),
    .o_overflow(ovf0)
  );

  hex_line_formatter #(
    .L_DEPTH(3), .G_UPPERCASE(1'b1), .G_EOL(8'h0A)
  ) u_up (
    .i_clk(clk), .i_rst(rst), .i_value(value),
    .i_value_wr(wr), .i_terminate_str(term),
    .o_char(char1), .o_char_valid(valid1),
    .i_char_ready(ready), .o_done(done1),
    .o_overflow(ovf1)
  );

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n, input bit up);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (up ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  task automatic exp_line(input logic [7:0] v);
    q0.push_back(hx(v[7:4], 1'b0));
    q0.push_back(hx(v[3:0], 1'b0));
    q0.push_back(8'h0A);
    q1.push_back(hx(v[7:4], 1'b1));
    q1.push_back(hx(v[3:0], 1'b1));
    q1.push_back(8'h0A);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_val(input logic [7:0] v);
    value = v;
    wr    = 1'b1;
    step();
    wr    = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    @(negedge clk);
    while (!valid0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!valid0) begin
      n_total++;
      $display("FAIL %s: got valid=0 want valid=1 within 20", nm);
    end
  endtask

  task automatic drain(input string nm);
    int k = 0;
    @(negedge clk);
    while ((q0.size() != 0 || q1.size() != 0 || valid0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (q0.size() == 0 && q1.size() == 0 && !valid0) n_pass++;
    else $display("FAIL %s: got %0d/%0d bytes left want 0/0",
                  nm, q0.size(), q1.size());
  endtask

  // Monitor: pops on every transfer and enforces the stall rule.
  logic       st0 = 1'b0, st1 = 1'b0;
  logic [7:0] pc0, pc1;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      st0 = 1'b0;
      st1 = 1'b0;
    end else begin
      if (st0) begin
        chk("lo_stall", char0, pc0);
        chk("lo_stall_v", 8'(valid0), 8'h01);
      end
      if (st1) begin
        chk("up_stall", char1, pc1);
        chk("up_stall_v", 8'(valid1), 8'h01);
      end
      if (valid0 && ready) begin
        if (q0.size() == 0) begin
          n_total++;
          $display("FAIL lo_extra: got %h want nothing", char0);
        end else chk("lo_char", char0, q0.pop_front());
      end
      if (valid1 && ready) begin
        if (q1.size() == 0) begin
          n_total++;
          $display("FAIL up_extra: got %h want nothing", char1);
        end else chk("up_char", char1, q1.pop_front());
      end
      st0 = valid0 && !ready;
      pc0 = char0;
      st1 = valid1 && !ready;
      pc1 = char1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int eol;
    int k;
    rst   = 1'b1;
    value = 8'h00;
    wr    = 1'b0;
    term  = 1'b0;
    ready = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_char", char0, 8'h00);
    chk("rst_valid", 8'(valid0), 8'h00);
    chk("rst_done", 8'(done0), 8'h00);
    chk("rst_ovf", 8'(ovf0), 8'h00);
    chk("rst_char_up", char1, 8'h00);
    step();
    rst = 1'b0;

    // Single value, exact latency and spacing
    ready = 1'b1;
    exp_line(8'hA5);
    wr_val(8'hA5);
    @(negedge clk);
    chk("t1_lat1", 8'(valid0), 8'h00);
    @(negedge clk);
    chk("t1_hi_v", 8'(valid0), 8'h01);
    chk("t1_hi", char0, 8'h61);
    chk("t1_hi_up", char1, 8'h41);
    @(negedge clk);
    chk("t1_lo", char0, 8'h35);
    @(negedge clk);
    chk("t1_eol", char0, 8'h0A);
    @(negedge clk);
    chk("t1_end_v", 8'(valid0), 8'h00);
    drain("t1");

    // Back-to-back values, no bubbles
    step();
    exp_line(8'h00);
    exp_line(8'hFF);
    exp_line(8'h3C);
    value = 8'h00;
    wr    = 1'b1;
    step();
    value = 8'hFF;
    step();
    value = 8'h3C;
    step();
    wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t2_gap", 8'(valid0), 8'h01);
    end
    @(negedge clk);
    chk("t2_end", 8'(valid0), 8'h00);
    drain("t2");

    // Backpressure holds the high digit
    step();
    ready = 1'b0;
    exp_line(8'h7E);
    wr_val(8'h7E);
    wait_valid("t3_valid");
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold", char0, 8'h37);
      @(negedge clk);
    end
    step();
    ready = 1'b1;
    drain("t3");

    // Overflow: ten writes with the sink stalled
    step();
    ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      value = 8'(i);
      wr    = 1'b1;
      if (i <= 9) exp_line(8'(i));
      if (i == 10) begin
        @(negedge clk);
        chk("t4_pre_ovf", 8'(ovf0), 8'h00);
      end
      step();
    end
    wr = 1'b0;
    @(negedge clk);
    chk("t4_ovf", 8'(ovf0), 8'h01);
    chk("t4_ovf_up", 8'(ovf1), 8'h01);
    chk("t4_hold_hi", char0, 8'h30);
    step();
    ready = 1'b1;
    drain("t4");

    // Reset in S_LO, then uppercase check
    step();
    exp_line(8'h5A);
    wr_val(8'h5A);
    wait_valid("t6_valid");
    step();
    ready = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    chk("t6_in_lo", char0, 8'h61);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 8'(valid0), 8'h00);
    chk("t6_done", 8'(done0), 8'h00);
    chk("t6_ovf", 8'(ovf0), 8'h00);
    chk("t6_ovf_up", 8'(ovf1), 8'h00);
    chk("t6_char", char0, 8'h00);
    q0.delete();
    q1.delete();
    step();
    ready = 1'b1;
    exp_line(8'hBE);
    wr_val(8'hBE);
    wait_valid("t6_be");
    chk("t6_be_up", char1, 8'h42);
    chk("t6_be_lo", char0, 8'h62);
    drain("t6");

    // Termination drain and sticky done
    step();
    exp_line(8'h12);
    exp_line(8'h34);
    value = 8'h12;
    wr    = 1'b1;
    step();
    value = 8'h34;
    term  = 1'b1;
    step();
    term  = 1'b0;
    value = 8'h56;
    step();
    wr  = 1'b0;
    eol = 0;
    k   = 0;
    while (eol < 2 && k < 50) begin
      @(negedge clk);
      k++;
      chk("t5_early", 8'(done0), 8'h00);
      if (valid0 && ready && char0 == 8'h0A) eol++;
    end
    if (eol < 2) begin
      n_total++;
      $display("FAIL t5_eol: got %0d lines want 2", eol);
    end
    @(negedge clk);
    @(negedge clk);
    chk("t5_done", 8'(done0), 8'h01);
    chk("t5_done_up", 8'(done1), 8'h01);
    chk("t5_idle", 8'(valid0), 8'h00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_sticky", 8'(done0), 8'h01);
      chk("t5_no56", 8'(valid0), 8'h00);
    end
    drain("t5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
